uart_tx_fifo: RTL

- Buffered byte source for the UART transmit stage. Sits directly upstream of the bit-level serial writer and drives that writer's `send`/`data` pair.
- Producers (alarm logger, command responder) push bytes at any rate up to one per Clock. The block drains them one at a time using the writer's level `ready` and rising-edge `send` protocol.
- Producers never need to track the serial line state.

---
 rtl/uart_tx_fifo.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding the bit-level UART serial writer.
// Producers push bytes at up to one per Clock; a small drain FSM hands the
// head byte to the writer using its level tx_ready / rising-edge tx_send
// handshake, so producers never need to look at the serial line.
// Optional build macro UART_TX_FIFO_OVERFLOW_EN adds overflow / overflow_clr /
// drop_cnt for reporting dropped pushes; without it drops are silent.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  busy,
  input  logic                  tx_ready,
  output logic                  tx_send,
  output logic [7:0]            tx_data
`ifdef UART_TX_FIFO_OVERFLOW_EN
  ,
  input  logic                  overflow_clr,
  output logic                  overflow,
  output logic [7:0]            drop_cnt
`endif
);

  localparam int                DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_C   = (DEPTH_LOG2+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  state_t                state_q;
  logic                  tx_send_q;
  logic [7:0]            tx_data_q;

  logic push, pop, drop;

  // The writer pulling tx_ready low while we offer a byte is the acceptance
  // point; that is the only place a byte leaves the buffer.
  assign pop  = (state_q == S_SEND) && !tx_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push = wr_en && ((count_q != DEPTH_C) || pop);
  assign drop = wr_en && !push;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign busy    = !empty || (state_q != S_IDLE);
  assign tx_send = tx_send_q;
  assign tx_data = tx_data_q;

  // Occupancy next-state: simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset since pointers/count define validity.
  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Drain FSM with registered tx_send/tx_data. tx_data is only loaded when
  // leaving S_IDLE, so it is stable for the whole time tx_send is high, and
  // S_HOLD plus the S_IDLE re-check give at least two low cycles between bytes.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      tx_send_q <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty && tx_ready) begin
            tx_data_q <= mem_q[rd_ptr_q];
            tx_send_q <= 1'b1;
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          if (!tx_ready) begin
            tx_send_q <= 1'b0;
            state_q   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (tx_ready) state_q <= S_IDLE;
        end
        default: begin
          tx_send_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic       overflow_q;
  logic [7:0] drop_cnt_q;

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  // Sticky drop flag and saturating drop counter. A drop in the clear cycle
  // keeps the flag set and restarts the counter at one so it is not lost.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'h00;
    end else begin
      if (drop)              overflow_q <= 1'b1;
      else if (overflow_clr) overflow_q <= 1'b0;
      if (overflow_clr)                        drop_cnt_q <= drop ? 8'h01 : 8'h00;
      else if (drop && (drop_cnt_q != 8'hFF))  drop_cnt_q <= drop_cnt_q + 8'h01;
    end
  end
`endif

endmodule
